serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Parametrised multi-bit subtractor that computes `a - b - bin` over `WIDTH` bits, `DIGIT` bits per clock, LSB digit first. Each step reuses full-subtractor bit cells and keeps the borrow in a register between cycles. Operands enter and results leave through valid/ready handshakes. The block is the area-lean arithmetic unit for datapaths where a single-cycle `WIDTH`-bit subtractor is too large or too slow.

## Interface
- `WIDTH`, default 8: operand/result width; must be ≥ 2.
- `DIGIT`, default 1: bits processed per cycle; `WIDTH % DIGIT == 0` (elaboration error otherwise).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operands present.
- `in_ready` output 1: block can accept operands.
- `a` input `WIDTH`: minuend.
- `b` input `WIDTH`: subtrahend.
- `bin` input 1: borrow-in.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts result.
- `diff` output `WIDTH`: `(a - b - bin) mod 2^WIDTH`.
- `bout` output 1: unsigned borrow-out, 1 iff `a < b + bin`.
- `ovf` output 1: two's-complement overflow, `a[MSB] != b[MSB] && diff[MSB] != a[MSB]`.

## Operation
- The FSM has three states: IDLE, RUN and DONE. `N = WIDTH/DIGIT` steps; the step counter is `$clog2(N)+1` bits wide.
- `in_ready = (state==IDLE) || (state==DONE && out_ready)`. It is combinational, so it reads 1 while reset is asserted.
- **Accept:** `in_valid && in_ready` at an edge.
  - Capture `a`, `b` into shift registers and `bin` into the borrow register.
  - Clear the step counter and go to RUN.
  - Operand inputs are ignored at all other times.
- **RUN, each cycle:**
  - The digit cell consumes the low `DIGIT` bits of `a_sh`/`b_sh` plus the borrow register.
  - It produces `DIGIT` difference bits, which are shifted into `diff` from the MSB end. The digit borrow-out is registered.
  - The operand shift registers shift right by `DIGIT`.
  - After step `N-1`: go to DONE. `bout` = final borrow, and `ovf` is computed from the captured `a`/`b` MSBs and the final `diff` MSB.
- **DONE:**
  - `out_valid=1`. `diff`, `bout` and `ovf` are held stable until `out_valid && out_ready`.
  - On handshake: go to IDLE, or go straight to RUN if `in_valid` is high on the same edge (back-to-back accept).
- `out_valid` is 0 in IDLE and RUN. The `diff` register may hold partial bits during RUN, and consumers must not sample it.
- **Reset asserted in any state:**
  - The operation is aborted and the FSM returns to IDLE.
  - `out_valid=0`, `diff=0`, `bout=0`, `ovf=0`; the counter, shift registers and borrow register are cleared.
  - No result is emitted for an aborted operation.
- All arithmetic is modular on `WIDTH` bits. `bin` propagates exactly like a borrow into bit 0.

## Timing
- **Latency:** accept at edge k gives `out_valid=1` after edge k+N. For WIDTH=8, DIGIT=1 that is 8 cycles; for DIGIT=4 it is 2 cycles.
- **Throughput:** one result per N+1 cycles with `out_ready` tied high and back-to-back accept. It is one per N+2 cycles if the producer only presents operands in IDLE.
- **Outputs after reset release:** `out_valid=0`, `diff=0`, `bout=0`, `ovf=0`, `in_ready=1`.
- **Backpressure:** `out_ready` low in DONE holds state and outputs indefinitely, with `in_ready=0`.
- Input and output handshakes on the same edge in DONE are legal: the old result is retired and the new operands are captured.
- There are no combinational paths from `a`, `b` or `bin` to any output. `in_ready` depends combinationally on `out_ready` only.

## Structure
- A shared package `sub_pkg` holds:
  - the state enum, with IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - the digit-width check function used for the elaboration assertion.
- Sub-module `fs_digit #(DIGIT)`: a combinational ripple of `DIGIT` full-subtractor cells.
  - Each cell computes `d = x^y^c` and `c_out = (~x&y) | (y&c) | (c&~x)`.
  - Ports: `x[DIGIT]`, `y[DIGIT]`, `cin`, `d[DIGIT]`, `cout`.
- The top level holds the FSM, step counter, shift registers, borrow register and output registers.

## Test plan
- WIDTH=8, DIGIT=1; `a=0x35`, `b=0x12`, `bin=0` → `diff=0x23`, `bout=0`, `ovf=0`, with `out_valid` rising exactly 8 cycles after accept.
- `a=0x00`, `b=0x01`, `bin=0` → `diff=0xFF`, `bout=1`, `ovf=0`. Then `a=0x10`, `b=0x10`, `bin=1` → `diff=0xFF`, `bout=1`, `ovf=0`.
- `a=0x80`, `b=0x01`, `bin=0` → `diff=0x7F`, `bout=0`, `ovf=1`. Then `a=0x7F`, `b=0xFF` → `diff=0x80`, `bout=1`, `ovf=1`.
- **Backpressure:** hold `out_ready=0` for 5 cycles in DONE → outputs stable and `in_ready=0`. Then raise `out_ready` with `in_valid=1` carrying the next operands → both handshakes on one edge, and the next result arrives 8 cycles later.
- **Reset mid-operation:** assert `rst_n=0` at RUN step 3 → all outputs 0 immediately (asynchronously) and no `out_valid` for that operation. After release, a new operation produces the correct result.
- WIDTH=16, DIGIT=4; `a=0x1234`, `b=0x4321`, `bin=1` → `diff=0xCF12`, `bout=1`, `ovf=0`, latency 4 cycles. Also run random self-checking against `a-b-bin` for 1000 operands.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// sub_pkg: shared definitions for the serial subtractor.
//   state_e   - FSM state encoding (IDLE / RUN / DONE)
//   digit_ok  - legality check for the WIDTH / DIGIT pair, evaluated at elaboration
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic bit digit_ok(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result handshake bundle for serial_subtractor.
//   in_valid/in_ready  - operand handshake (a, b, bin)
//   out_valid/out_ready - result handshake (diff, bout, ovf)
//   slave modport  - the subtractor side
//   master modport - the producer/consumer side
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor_fs_digit.sv
// fs_digit: combinational ripple of DIGIT full-subtractor cells.
//   x, y  - DIGIT-bit minuend / subtrahend slices (LSB = bit 0)
//   cin   - borrow into bit 0
//   d     - DIGIT difference bits
//   cout  - borrow out of the top cell
module fs_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] d,
  output logic             cout
);

  always_comb begin
    logic c;
    c = cin;
    d = '0;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = x[i] ^ y[i] ^ c;
      c    = (~x[i] & y[i]) | (y[i] & c) | (c & ~x[i]);
    end
    cout = c;
  end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes (a - b - bin) mod 2^WIDTH, DIGIT bits per clock,
// LSB digit first, with the borrow carried in a register between steps.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; aborts any operation in flight
//   bus   - serial_subtractor_if slave: operands in, diff/bout/ovf out
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;

  if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_digit
    $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q, diff_q;
  logic               borrow_q, bout_q, ovf_q, a_msb_q, b_msb_q;

  logic               accept, last_step;
  logic [DIGIT-1:0]   dig_d;
  logic               dig_cout;
  logic [WIDTH+DIGIT-1:0] diff_cat;
  logic [WIDTH-1:0]   diff_shift;

  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_step = (cnt_q == CW'(N - 1));

  fs_digit #(.DIGIT(DIGIT)) u_digit (
    .x    (a_sh_q[DIGIT-1:0]),
    .y    (b_sh_q[DIGIT-1:0]),
    .cin  (borrow_q),
    .d    (dig_d),
    .cout (dig_cout)
  );

  // New digit enters at the MSB end; concatenate-then-shift also covers DIGIT == WIDTH.
  assign diff_cat   = {dig_d, diff_q} >> DIGIT;
  assign diff_shift = diff_cat[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = bus.in_valid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_sh_q   <= bus.a;
        b_sh_q   <= bus.b;
        borrow_q <= bus.bin;
        a_msb_q  <= bus.a[WIDTH-1];
        b_msb_q  <= bus.b[WIDTH-1];
        cnt_q    <= '0;
      end else if (state_q == RUN) begin
        a_sh_q   <= a_sh_q >> DIGIT;
        b_sh_q   <= b_sh_q >> DIGIT;
        borrow_q <= dig_cout;
        diff_q   <= diff_shift;
        cnt_q    <= cnt_q + CW'(1);
        if (last_step) begin
          bout_q <= dig_cout;
          ovf_q  <= (a_msb_q != b_msb_q) && (diff_shift[WIDTH-1] != a_msb_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8))  if8 ();
  serial_subtractor_if #(.WIDTH(16)) if16 ();

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- 8-bit helpers ----------------
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    if8.a = a; if8.b = b; if8.bin = bi; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
  endtask

  task automatic wait8(output int cyc);
    cyc = 0;
    while (!if8.out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic res8(input string tag, input logic [7:0] ed, input logic eb, input logic eo);
    chk({tag, "_diff"}, 32'(if8.diff), 32'(ed));
    chk({tag, "_bout"}, 32'(if8.bout), 32'(eb));
    chk({tag, "_ovf"},  32'(if8.ovf),  32'(eo));
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input logic [7:0] ed, input logic eb, input logic eo);
    int cyc;
    if8.out_ready = 1'b1;
    start8(a, b, bi);
    wait8(cyc);
    chk({tag, "_lat"}, 32'(cyc), 32'd8);
    res8(tag, ed, eb, eo);
    @(posedge clk); #1;
  endtask

  // ---------------- 16-bit helpers ----------------
  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bi,
                      input logic [17:0] exp, input bit chk_lat);
    int cyc;
    if16.out_ready = 1'b1;
    if16.a = a; if16.b = b; if16.bin = bi; if16.in_valid = 1'b1;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    cyc = 0;
    while (!if16.out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (chk_lat) chk({tag, "_lat"}, 32'(cyc), 32'd4);
    else if (cyc >= 40) chk({tag, "_timeout"}, 32'(cyc), 32'd4);
    chk({tag, "_res"}, 32'({if16.ovf, if16.bout, if16.diff}), 32'(exp));
    @(posedge clk); #1;
  endtask

  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic bi);
    logic [16:0] full;
    logic        ov;
    full = {1'b0, a} - {1'b0, b} - {16'd0, bi};
    ov   = (a[15] != b[15]) && (full[15] != a[15]);
    return {ov, full[16], full[15:0]};
  endfunction

  initial begin
    int cyc;
    int seen;
    logic [15:0] ra, rb;
    logic        rbi;

    if8.in_valid = 0;  if8.a = '0;  if8.b = '0;  if8.bin = 0;  if8.out_ready = 1;
    if16.in_valid = 0; if16.a = '0; if16.b = '0; if16.bin = 0; if16.out_ready = 1;

    // Reset state (reset asserted)
    #2;
    chk("rst_in_ready", 32'(if8.in_ready), 32'd1);
    chk("rst_out_valid", 32'(if8.out_valid), 32'd0);
    chk("rst_outs", 32'({if8.diff, if8.bout, if8.ovf}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(if8.in_ready), 32'd1);
    chk("rel_out_valid", 32'(if8.out_valid), 32'd0);
    chk("rel16_outs", 32'({if16.out_valid, if16.diff, if16.bout, if16.ovf}), 32'd0);

    // Directed 8-bit vectors
    op8("v35m12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);
    op8("v00m01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    op8("v10m10b", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
    op8("v80m01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    op8("v7FmFF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    chk("idle_in_ready", 32'(if8.in_ready), 32'd1);

    // Backpressure, then simultaneous retire + accept
    if8.out_ready = 1'b0;
    start8(8'h35, 8'h12, 1'b0);
    wait8(cyc);
    chk("bp_lat", 32'(cyc), 32'd8);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(if8.out_valid), 32'd1);
      chk("bp_in_ready", 32'(if8.in_ready), 32'd0);
      res8("bp_hold", 8'h23, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    res8("bp_final", 8'h23, 1'b0, 1'b0);
    if8.out_ready = 1'b1;
    #1;
    chk("bp_in_ready_hi", 32'(if8.in_ready), 32'd1);
    start8(8'h7F, 8'hFF, 1'b0);
    chk("b2b_valid_drop", 32'(if8.out_valid), 32'd0);
    wait8(cyc);
    chk("b2b_lat", 32'(cyc), 32'd8);
    res8("b2b", 8'h80, 1'b1, 1'b1);
    @(posedge clk); #1;

    // Reset mid-operation (RUN step 3)
    start8(8'hFF, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(if8.out_valid), 32'd0);
    chk("midrst_outs", 32'({if8.diff, if8.bout, if8.ovf}), 32'd0);
    chk("midrst_in_ready", 32'(if8.in_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (if8.out_valid) seen++;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);
    op8("after_rst", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);

    // 16-bit, DIGIT=4
    op16("w16_dir", 16'h1234, 16'h4321, 1'b1, {1'b0, 1'b1, 16'hCF12}, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rbi = 1'($urandom);
      op16("w16_rnd", ra, rb, rbi, model16(ra, rb, rbi), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
